// File: rtl/wb_rr_arbiter_if.sv
// Signal bundle between the initiator/target environment and wb_rr_arbiter.
// Initiator k owns slice k of the packed address and write-data vectors.
interface wb_rr_arbiter_if #(
    parameter int N_INITIATORS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
);
    logic [N_INITIATORS*ADDR_WIDTH-1:0] i_adr;
    logic [N_INITIATORS*DATA_WIDTH-1:0] i_dat_w;
    logic [N_INITIATORS-1:0]            i_we;
    logic [N_INITIATORS-1:0]            i_stb;
    logic [N_INITIATORS-1:0]            i_cyc;
    logic [DATA_WIDTH-1:0]              i_dat_r;
    logic [N_INITIATORS-1:0]            i_ack;
    logic [N_INITIATORS-1:0]            i_err;
    logic [ADDR_WIDTH-1:0]              t_adr;
    logic [DATA_WIDTH-1:0]              t_dat_w;
    logic                               t_we;
    logic                               t_stb;
    logic                               t_cyc;
    logic [DATA_WIDTH-1:0]              t_dat_r;
    logic                               t_ack;
    logic [N_INITIATORS-1:0]            grant;

    // The arbiter's own view of the bundle.
    modport slave (
        input  i_adr, i_dat_w, i_we, i_stb, i_cyc, t_dat_r, t_ack,
        output i_dat_r, i_ack, i_err, t_adr, t_dat_w, t_we, t_stb, t_cyc, grant
    );

    // The view of whatever drives initiators and models the target.
    modport master (
        output i_adr, i_dat_w, i_we, i_stb, i_cyc, t_dat_r, t_ack,
        input  i_dat_r, i_ack, i_err, t_adr, t_dat_w, t_we, t_stb, t_cyc, grant
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N initiators share one target, one cyc frame per grant.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-beat watchdog with i_err reporting.
module wb_rr_arbiter #(
    parameter int N_INITIATORS   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clock,
    input  logic           reset,
    wb_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_INITIATORS);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [IDX_W-1:0] last_reg;

    logic [ADDR_WIDTH-1:0] adr_arr [N_INITIATORS];
    logic [DATA_WIDTH-1:0] dat_arr [N_INITIATORS];
    logic [IDX_W-1:0]      cand_idx [N_INITIATORS];
    logic [N_INITIATORS-1:0] rot_req;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic                  owned;
    logic                  timeout;

    if (N_INITIATORS < 2 || N_INITIATORS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_rr_arbiter: N_INITIATORS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    assign owned = (state_reg == OWNED);

    // Candidate gi is the initiator gi+1 places after the last owner, wrapped mod N.
    for (genvar gi = 0; gi < N_INITIATORS; gi++) begin : g_slice
        logic [IDX_W:0] cand_sum;

        assign adr_arr[gi]  = bus.i_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_arr[gi]  = bus.i_dat_w[gi*DATA_WIDTH +: DATA_WIDTH];
        assign cand_sum     = {1'b0, last_reg} + (IDX_W+1)'(gi + 1);
        assign cand_idx[gi] = (cand_sum >= (IDX_W+1)'(N_INITIATORS))
                            ? IDX_W'(cand_sum - (IDX_W+1)'(N_INITIATORS))
                            : IDX_W'(cand_sum);
        assign rot_req[gi]  = bus.i_cyc[cand_idx[gi]];

        assign bus.grant[gi] = owned && (owner_reg == IDX_W'(gi));
        assign bus.i_ack[gi] = owned && (owner_reg == IDX_W'(gi)) && bus.t_ack;
        assign bus.i_err[gi] = timeout && (owner_reg == IDX_W'(gi));
    end

    // Nearest requester in rotation order wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int d = N_INITIATORS - 1; d >= 0; d--) begin
            if (rot_req[d]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            last_reg  <= IDX_W'(N_INITIATORS - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        owner_reg <= pick_idx;
                        state_reg <= OWNED;
                    end
                end
                OWNED: begin
                    if (!bus.i_cyc[owner_reg]) begin
                        last_reg  <= owner_reg;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_count_reg;
    logic             stall;

    assign stall   = owned && bus.i_stb[owner_reg] && !bus.t_ack;
    assign timeout = stall && (wd_count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !stall || timeout) begin
            wd_count_reg <= '0;
        end else begin
            wd_count_reg <= wd_count_reg + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A watchdog hit withdraws stb/cyc for that cycle; ownership is untouched.
    always_comb begin
        bus.i_dat_r = bus.t_dat_r;
        bus.t_adr   = '0;
        bus.t_dat_w = '0;
        bus.t_we    = 1'b0;
        bus.t_stb   = 1'b0;
        bus.t_cyc   = 1'b0;
        if (owned) begin
            bus.t_adr   = adr_arr[owner_reg];
            bus.t_dat_w = dat_arr[owner_reg];
            bus.t_we    = bus.i_we[owner_reg];
            bus.t_stb   = bus.i_stb[owner_reg] && !timeout;
            bus.t_cyc   = bus.i_cyc[owner_reg] && !timeout;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic against a frame-level model.
module tb_wb_rr_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    wb_rr_arbiter_if #(.N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_rr_arbiter #(
        .N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle_n = 0;

    // Model: owner -1 means no frame granted; last is the previous owner.
    int m_owner, m_last, m_cnt;
    int n_owner, n_last, n_cnt;
    logic [N-1:0] m_ack;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cycle_n, observed, expected);
        end
    endtask

    task automatic model_step();
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic          e_we, e_stb, e_cyc;
        logic [N-1:0]  e_grant, e_ack, e_err;
        bit            to;
        e_adr = '0; e_dat = '0; e_we = 0; e_stb = 0; e_cyc = 0;
        e_grant = '0; e_ack = '0; e_err = '0;
        to = 0;
`ifdef WB_ARB_TIMEOUT_EN
        if (m_owner >= 0 && bus.i_stb[m_owner] && !bus.t_ack && m_cnt == TO - 1) to = 1;
`endif
        if (m_owner >= 0) begin
            e_adr   = bus.i_adr[m_owner*AW +: AW];
            e_dat   = bus.i_dat_w[m_owner*DW +: DW];
            e_we    = bus.i_we[m_owner];
            e_stb   = bus.i_stb[m_owner] && !to;
            e_cyc   = bus.i_cyc[m_owner] && !to;
            e_grant = N'(1) << m_owner;
            e_ack   = bus.t_ack ? (N'(1) << m_owner) : '0;
            e_err   = to ? (N'(1) << m_owner) : '0;
        end
        check("t_adr", bus.t_adr, e_adr);
        check("t_dat_w", bus.t_dat_w, e_dat);
        check("t_we", bus.t_we, e_we);
        check("t_stb", bus.t_stb, e_stb);
        check("t_cyc", bus.t_cyc, e_cyc);
        check("grant", bus.grant, e_grant);
        check("i_ack", bus.i_ack, e_ack);
        check("i_err", bus.i_err, e_err);
        check("i_dat_r", bus.i_dat_r, bus.t_dat_r);
        m_ack = e_ack;

        n_owner = m_owner;
        n_last  = m_last;
        n_cnt   = 0;
        if (m_owner >= 0 && bus.i_stb[m_owner] && !bus.t_ack && !to) n_cnt = m_cnt + 1;
        if (m_owner < 0) begin
            for (int d = 1; d <= N; d++) begin
                int k;
                k = (m_last + d) % N;
                if (bus.i_cyc[k]) begin
                    n_owner = k;
                    break;
                end
            end
        end else if (!bus.i_cyc[m_owner]) begin
            n_last  = m_owner;
            n_owner = -1;
        end
        if (reset) begin
            n_owner = -1;
            n_last  = N - 1;
            n_cnt   = 0;
        end
    endtask

    // One clock: model checks mid-cycle, commits at the edge, returns 1 time unit later.
    task automatic tick();
        @(negedge clock);
        model_step();
        @(posedge clock);
        m_owner = n_owner;
        m_last  = n_last;
        m_cnt   = n_cnt;
        cycle_n++;
        #1;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        bus.i_cyc[k] = cyc;
        bus.i_stb[k] = stb;
        bus.i_we[k]  = we;
        bus.i_adr[k*AW +: AW] = adr;
        bus.i_dat_w[k*DW +: DW] = dat;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq[$];
        int gaps[$];
        int idle_run;
        logic [N-1:0] cool;
        int beats_left [N];
        bit in_frame [N];
        logic expect_err;

        bus.i_adr = '0; bus.i_dat_w = '0; bus.i_we = '0; bus.i_stb = '0; bus.i_cyc = '0;
        bus.t_dat_r = '0; bus.t_ack = 1'b0;
        m_ack = '0;
        @(posedge clock);
        #1;
        m_owner = -1; m_last = N - 1; m_cnt = 0;
        check("rst_grant", bus.grant, 0);
        check("rst_t_cyc", bus.t_cyc, 0);
        check("rst_t_stb", bus.t_stb, 0);
        check("rst_i_ack", bus.i_ack, 0);
        tick();
        reset = 1'b0;

        // Single write request from initiator 0.
        drive(0, 1, 1, 1, 32'h100, 32'hA5A5A5A5);
        tick();
        check("single_grant", bus.grant, 3'b001);
        check("single_adr", bus.t_adr, 32'h100);
        check("single_dat", bus.t_dat_w, 32'hA5A5A5A5);
        bus.t_ack = 1'b1;
        #1;
        check("single_ack", bus.i_ack, 3'b001);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.t_ack = 1'b0;
        tick();
        tick();

        // Two contending initiators, one-beat frames.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.t_ack = 1'b1;
        drive(0, 1, 1, 0, 32'h10, 0);
        drive(1, 1, 1, 0, 32'h20, 0);
        cool = '0;
        idle_run = 0;
        for (int c = 0; c < 40 && seq.size() < 8; c++) begin
            tick();
            if (bus.grant != 0) begin
                if (seq.size() == 0 || idle_run > 0) begin
                    seq.push_back($clog2(bus.grant));
                    gaps.push_back(idle_run);
                end
                idle_run = 0;
            end else if (seq.size() > 0) begin
                idle_run++;
            end
            for (int k = 0; k < 2; k++) begin
                if (cool[k]) begin
                    bus.i_cyc[k] = 1'b1;
                    bus.i_stb[k] = 1'b1;
                    cool[k] = 1'b0;
                end else if (m_ack[k] && bus.i_stb[k]) begin
                    bus.i_cyc[k] = 1'b0;
                    bus.i_stb[k] = 1'b0;
                    cool[k] = 1'b1;
                end
            end
        end
        check("alt_frames", seq.size(), 8);
        for (int i = 0; i < seq.size(); i++) begin
            check("alt_owner", seq[i], i % 2);
            if (i > 0) check("alt_gap", gaps[i], 1);
        end
        bus.i_cyc = '0; bus.i_stb = '0; bus.t_ack = 1'b0;
        tick();
        tick();

        // Bus lock: initiator 1 runs three beats while 0 waits.
        drive(1, 1, 1, 1, 32'h200, 32'h11);
        tick();
        check("lock_grant", bus.grant, 3'b010);
        drive(0, 1, 1, 1, 32'h300, 32'h22);
        for (int b = 0; b < 3; b++) begin
            bus.t_ack = 1'b1;
            bus.i_adr[1*AW +: AW] = 32'h200 + b;
            #1;
            check("lock_hold", bus.grant, 3'b010);
            check("lock_ack", bus.i_ack, 3'b010);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0);
        bus.t_ack = 1'b0;
        tick();
        check("lock_release", bus.grant, 3'b000);
        tick();
        check("lock_next", bus.grant, 3'b001);

        // Read data broadcast, ack only to the owner.
        drive(0, 1, 1, 0, 32'h400, 0);
        bus.t_dat_r = 32'h12345678;
        bus.t_ack = 1'b1;
        #1;
        check("rd_ack", bus.i_ack, 3'b001);
        check("rd_data", bus.i_dat_r, 32'h12345678);
        tick();

        // Reset in the middle of an owned frame.
        bus.t_ack = 1'b0;
        drive(1, 1, 1, 0, 32'h500, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_cyc", bus.t_cyc, 0);
        check("mid_rst_stb", bus.t_stb, 0);
        check("mid_rst_grant", bus.grant, 0);
        reset = 1'b0;
        tick();
        check("mid_rst_first", bus.grant, 3'b001);

        // Hung target: initiator 0 stalls with stb high and no ack.
        for (int i = 1; i <= 12; i++) begin
`ifdef WB_ARB_TIMEOUT_EN
            expect_err = (i % TO == 0);
`else
            expect_err = 1'b0;
`endif
            check("wd_err", bus.i_err, expect_err ? 3'b001 : 3'b000);
            check("wd_stb", bus.t_stb, !expect_err);
            tick();
        end
        bus.i_cyc = '0; bus.i_stb = '0;
        tick();
        tick();

        // Random traffic from all initiators.
        for (int k = 0; k < N; k++) begin
            in_frame[k] = 0;
            beats_left[k] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                if (in_frame[k]) begin
                    if (m_ack[k] && bus.i_stb[k]) begin
                        beats_left[k]--;
                        if (beats_left[k] == 0) begin
                            in_frame[k] = 0;
                            drive(k, 0, 0, 0, 0, 0);
                        end else begin
                            drive(k, 1, ($urandom % 4) != 0, $urandom % 2, $urandom, $urandom);
                        end
                    end else if (!bus.i_stb[k] && ($urandom % 2) != 0) begin
                        bus.i_stb[k] = 1'b1;
                    end
                end else if ($urandom % 3 == 0) begin
                    in_frame[k] = 1;
                    beats_left[k] = 1 + $urandom % 3;
                    drive(k, 1, 1, $urandom % 2, $urandom, $urandom);
                end
            end
            bus.t_ack = ($urandom % 2) != 0;
            bus.t_dat_r = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
